// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with parity checking, line-break
// detection and a first-word-fall-through receive FIFO. Single clock domain;
// rxd is the only asynchronous input and is synchronised on entry.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic [DIV_W-1:0]     baud_div,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 break_strobe
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          ODD_PARITY = (PARITY == 1);
    localparam logic          HAS_PARITY = (PARITY != 0);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START      = 3'd1;
    localparam logic [2:0] ST_DATA       = 3'd2;
    localparam logic [2:0] ST_PARITY     = 3'd3;
    localparam logic [2:0] ST_STOP       = 3'd4;
    localparam logic [2:0] ST_BREAK_WAIT = 3'd5;

    // Synchroniser and baud tick
    logic             sync1;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    // Receiver state
    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic                 par_flag;

    // Frame completion events, all qualified by the mid-stop-bit tick
    logic stop_sample;
    logic data_zero;
    logic is_break;
    logic push_req;
    logic frame_bad;
    logic parity_bad;

    // FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 push_ok;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rxd;
            rx_s  <= sync1;
        end
    end

    assign tick = (div_cnt == '0);

    // Oversample tick down-counter; baud_div only takes effect on reload
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= baud_div;
        end else if (tick) begin
            div_cnt <= baud_div;
        end else begin
            div_cnt <= div_cnt - DIV_W'(1);
        end
    end

    // Receive FSM: advances only on oversample ticks, samples at mid-bit
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            par_flag  <= 1'b0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        par_bit  <= 1'b0;
                        par_flag <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick_cnt == MID_TICK) begin
                        tick_cnt <= '0;
                        state    <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt <= '0;
                        par_bit  <= rx_s;
                        par_flag <= ((^shift_reg) ^ rx_s) != ODD_PARITY;
                        state    <= ST_STOP;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt <= '0;
                        state    <= rx_s ? ST_IDLE : ST_BREAK_WAIT;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                ST_BREAK_WAIT: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Classify the completed frame at the stop-bit sample: word, break or framing fault
    always_comb begin
        stop_sample = (state == ST_STOP) && tick && (tick_cnt == LAST_TICK);
        data_zero   = (shift_reg == '0) && (!HAS_PARITY || !par_bit);
        is_break    = stop_sample && !rx_s && data_zero;
        push_req    = stop_sample && !is_break;
        frame_bad   = stop_sample && !rx_s && !data_zero;
        parity_bad  = stop_sample && par_flag && !is_break;
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_valid = !empty;
    assign pop      = rd_valid && rd_ready;
    assign push_ok  = push_req && (!full || pop);
    assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

    // FIFO storage; a simultaneous pop frees the slot a full-FIFO push lands in
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= shift_reg;
        end
    end

    // FIFO pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Registered status pulses, aligned with the cycle rd_valid reflects the push
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            overrun_err  <= 1'b0;
            break_strobe <= 1'b0;
        end else begin
            parity_err   <= parity_bad;
            frame_err    <= frame_bad;
            overrun_err  <= push_req && !push_ok;
            break_strobe <= is_break;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: one instance without parity and one
// with even parity, driven by serial frames with hand-computed results.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] baudDiv;

    logic       rxdA, rdReadyA, rdValidA;
    logic [7:0] rdDataA;
    logic       parityErrA, frameErrA, overrunErrA, breakStrobeA;

    logic       rxdB, rdReadyB, rdValidB;
    logic [7:0] rdDataB;
    logic       parityErrB, frameErrB, overrunErrB, breakStrobeB;

    int cycle = 0;
    int passCount = 0;
    int checkCount = 0;

    int parErrCntA = 0, frmErrCntA = 0, ovrCntA = 0, brkCntA = 0;
    int parErrCntB = 0, frmErrCntB = 0, ovrCntB = 0, brkCntB = 0;
    int riseCycleA = -1, riseCycleB = -1;
    int brkCycleA = -1, parErrCycleB = -1;
    logic prevValidA = 1'b0, prevValidB = 1'b0;

    uart_rx_fifo #(
        .DATA_BITS(8), .PARITY(0), .OVERSAMPLE(16), .DIV_W(8), .FIFO_DEPTH(4)
    ) dutA (
        .clk(clk), .reset(reset), .rxd(rxdA), .baud_div(baudDiv),
        .rd_data(rdDataA), .rd_valid(rdValidA), .rd_ready(rdReadyA),
        .parity_err(parityErrA), .frame_err(frameErrA),
        .overrun_err(overrunErrA), .break_strobe(breakStrobeA)
    );

    uart_rx_fifo #(
        .DATA_BITS(8), .PARITY(2), .OVERSAMPLE(16), .DIV_W(8), .FIFO_DEPTH(4)
    ) dutB (
        .clk(clk), .reset(reset), .rxd(rxdB), .baud_div(baudDiv),
        .rd_data(rdDataB), .rd_valid(rdValidB), .rd_ready(rdReadyB),
        .parity_err(parityErrB), .frame_err(frameErrB),
        .overrun_err(overrunErrB), .break_strobe(breakStrobeB)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter used to time-stamp events relative to frame starts
    always @(posedge clk) cycle <= cycle + 1;

    // Count status pulses and record rd_valid rising edges, sampled mid-cycle
    always @(negedge clk) begin
        if (parityErrA)   parErrCntA <= parErrCntA + 1;
        if (frameErrA)    frmErrCntA <= frmErrCntA + 1;
        if (overrunErrA)  ovrCntA    <= ovrCntA + 1;
        if (breakStrobeA) begin
            brkCntA   <= brkCntA + 1;
            brkCycleA <= cycle;
        end
        if (parityErrB) begin
            parErrCntB   <= parErrCntB + 1;
            parErrCycleB <= cycle;
        end
        if (frameErrB)    frmErrCntB <= frmErrCntB + 1;
        if (overrunErrB)  ovrCntB    <= ovrCntB + 1;
        if (breakStrobeB) brkCntB    <= brkCntB + 1;
        if (rdValidA && !prevValidA) riseCycleA <= cycle;
        if (rdValidB && !prevValidB) riseCycleB <= cycle;
        prevValidA <= rdValidA;
        prevValidB <= rdValidB;
    end

    // Compare one observed value against its expectation
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serialise one frame onto dutA (which=0) or dutB (which=1); optionally
    // raise rdReadyA for the cycle before edge popAt, or reset at offset resetAt
    task automatic applyStimulus(input int which, input logic [7:0] data,
                                 input bit withParity, input bit parityBit,
                                 input bit stopBit, input int popAt,
                                 input int resetAt, output int startCycle);
        logic [10:0] bits;
        int nbits;
        int bitClocks;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        if (withParity) begin
            bits[9]  = parityBit;
            bits[10] = stopBit;
            nbits    = 11;
        end else begin
            bits[9]  = stopBit;
            nbits    = 10;
        end
        bitClocks  = 16 * (int'(baudDiv) + 1);
        startCycle = 0;
        for (int i = 0; i < nbits * bitClocks; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) startCycle = cycle;
            if (resetAt > 0 && i == resetAt) begin
                reset = 1'b1;
                rxdA  = 1'b1;
                rxdB  = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                break;
            end
            if (which == 0) begin
                rxdA     = bits[i / bitClocks];
                rdReadyA = (popAt > 0) && (i == popAt - 1);
            end else begin
                rxdB = bits[i / bitClocks];
            end
        end
        rxdA     = 1'b1;
        rxdB     = 1'b1;
        rdReadyA = 1'b0;
    endtask

    task automatic popWord(input int which);
        @(posedge clk);
        #1;
        if (which == 0) rdReadyA = 1'b1;
        else            rdReadyB = 1'b1;
        @(posedge clk);
        #1;
        rdReadyA = 1'b0;
        rdReadyB = 1'b0;
    endtask

    initial begin
        int st;
        int lat;
        reset    = 1'b1;
        baudDiv  = 8'd0;
        rxdA     = 1'b1;
        rxdB     = 1'b1;
        rdReadyA = 1'b0;
        rdReadyB = 1'b0;
        waitCycles(3);
        checkOutput("reset rd_valid", rdValidA, 0);
        checkOutput("reset rd_data", rdDataA, 0);
        checkOutput("reset pulses", parityErrA + frameErrA + overrunErrA + breakStrobeA
                                    + parityErrB + frameErrB + overrunErrB + breakStrobeB, 0);
        reset = 1'b0;
        waitCycles(5);

        $display("[TB] basic 0x55 frame, no parity");
        applyStimulus(0, 8'h55, 0, 0, 1, 0, 0, st);
        checkOutput("t1 rd_valid", rdValidA, 1);
        checkOutput("t1 rd_data", rdDataA, 8'h55);
        checkOutput("t1 latency", riseCycleA - st, 155);
        checkOutput("t1 no pulses", parErrCntA + frmErrCntA + ovrCntA + brkCntA, 0);
        popWord(0);
        checkOutput("t1 empty after pop", rdValidA, 0);
        checkOutput("t1 rd_data after pop", rdDataA, 0);

        $display("[TB] even parity 0xA3, wrong then right parity bit");
        applyStimulus(1, 8'hA3, 1, 1, 1, 0, 0, st);
        checkOutput("t2 parity_err count", parErrCntB, 1);
        checkOutput("t2 rd_data", rdDataB, 8'hA3);
        checkOutput("t2 latency", riseCycleB - st, 171);
        checkOutput("t2 pulse aligned", parErrCycleB, riseCycleB);
        checkOutput("t2 frame_err", frmErrCntB, 0);
        popWord(1);
        applyStimulus(1, 8'hA3, 1, 0, 1, 0, 0, st);
        checkOutput("t2 good parity no pulse", parErrCntB, 1);
        checkOutput("t2 good rd_valid", rdValidB, 1);
        checkOutput("t2 good rd_data", rdDataB, 8'hA3);
        popWord(1);

        $display("[TB] false start");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            rxdA = 1'b0;
        end
        @(posedge clk);
        #1;
        rxdA = 1'b1;
        waitCycles(40);
        checkOutput("t3 no push", rdValidA, 0);
        applyStimulus(0, 8'h3C, 0, 0, 1, 0, 0, st);
        checkOutput("t3 rd_data", rdDataA, 8'h3C);
        checkOutput("t3 latency", riseCycleA - st, 155);
        popWord(0);

        $display("[TB] line break");
        st = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) st = cycle;
            rxdA = 1'b0;
        end
        @(posedge clk);
        #1;
        rxdA = 1'b1;
        waitCycles(40);
        checkOutput("t4 break count", brkCntA, 1);
        checkOutput("t4 break timing", brkCycleA - st, 155);
        checkOutput("t4 no frame_err", frmErrCntA, 0);
        checkOutput("t4 fifo empty", rdValidA, 0);
        applyStimulus(0, 8'h81, 0, 0, 1, 0, 0, st);
        checkOutput("t4 rd_data", rdDataA, 8'h81);
        popWord(0);

        $display("[TB] framing error");
        applyStimulus(0, 8'h55, 0, 0, 0, 0, 0, st);
        checkOutput("t4b frame_err count", frmErrCntA, 1);
        checkOutput("t4b word kept", rdDataA, 8'h55);
        checkOutput("t4b no break", brkCntA, 1);
        waitCycles(10);
        popWord(0);

        $display("[TB] overrun");
        for (int k = 1; k <= 4; k++) applyStimulus(0, 8'(k), 0, 0, 1, 0, 0, st);
        checkOutput("t5 no overrun at 4", ovrCntA, 0);
        applyStimulus(0, 8'h05, 0, 0, 1, 0, 0, st);
        checkOutput("t5 overrun at 5", ovrCntA, 1);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("t5 drain", rdDataA, k);
            popWord(0);
        end
        checkOutput("t5 empty", rdValidA, 0);
        for (int k = 1; k <= 4; k++) applyStimulus(0, 8'(k), 0, 0, 1, 0, 0, st);
        applyStimulus(0, 8'h05, 0, 0, 1, 155, 0, st);
        checkOutput("t5 no overrun with pop", ovrCntA, 1);
        for (int k = 2; k <= 5; k++) begin
            checkOutput("t5 drain with pop", rdDataA, k);
            popWord(0);
        end
        checkOutput("t5 empty again", rdValidA, 0);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'h99, 0, 0, 1, 0, 0, st);
        checkOutput("t6 preload", rdValidA, 1);
        applyStimulus(0, 8'h7E, 0, 0, 1, 0, 60, st);
        checkOutput("t6 rd_valid", rdValidA, 0);
        checkOutput("t6 rd_data", rdDataA, 0);
        checkOutput("t6 pulses", parityErrA + frameErrA + overrunErrA + breakStrobeA, 0);
        waitCycles(20);
        applyStimulus(0, 8'h12, 0, 0, 1, 0, 0, st);
        checkOutput("t6 rd_data after", rdDataA, 8'h12);
        checkOutput("t6 latency after", riseCycleA - st, 155);
        popWord(0);

        $display("[TB] baud_div = 3");
        baudDiv = 8'd3;
        waitCycles(10);
        applyStimulus(0, 8'hC5, 0, 0, 1, 0, 0, st);
        lat = riseCycleA - st;
        checkOutput("t7 rd_data", rdDataA, 8'hC5);
        checkOutput("t7 latency 64clk bits", int'(lat >= 608 && lat <= 616), 1);
        checkOutput("t7 no errors", frmErrCntA + ovrCntA, 2);
        popWord(0);
        checkOutput("t7 empty", rdValidA, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with configurable data width, parity mode and oversampling, plus a first-word-fall-through receive FIFO and line-break detection. It is the next-generation receive path of the uart project. It sits behind the chip input pins, and its break strobe can drive the design's reset-command path. All logic is synchronous to a single clock.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY, 0: 0 none, 1 odd, 2 even.
- OVERSAMPLE, 16: ticks per bit, even, ≥4.
- DIV_W, 8: width of baud_div.
- FIFO_DEPTH, 4: entries, power of 2, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rxd  in  1  asynchronous serial input, idle high.
- baud_div  in  DIV_W  oversample tick period minus 1, in clk cycles.
- rd_data  out  DATA_BITS  FIFO head word.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  pop request; pop occurs when rd_valid && rd_ready.
- parity_err  out  1  one-cycle pulse: received parity wrong.
- frame_err  out  1  one-cycle pulse: stop bit sampled low (non-break).
- overrun_err  out  1  one-cycle pulse: word dropped because FIFO full.
- break_strobe  out  1  one-cycle pulse: break detected.

## Operation
- rxd passes through a 2-flop synchroniser, reset value 1. All sampling uses the synchronised value rx_s.
- Tick generator:
  - Down-counter loads baud_div and emits tick when it reaches 0, so one tick every baud_div+1 clocks.
  - baud_div is sampled only at reload.
  - Counter reloads on reset.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT. A tick counter (0..OVERSAMPLE-1) and a bit counter run inside the states.
- IDLE:
  - On a tick with rx_s=0, go to START with tick count cleared.
- START:
  - At tick OVERSAMPLE/2-1 (mid-bit), sample rx_s.
  - If 1: false start, return to IDLE.
  - If 0: go to DATA. Counts clear.
- DATA:
  - Sample every OVERSAMPLE ticks; shift into the data register LSB first.
  - After DATA_BITS samples, go to PARITY if PARITY≠0, else STOP.
- PARITY:
  - Sample one bit.
  - Error if the XOR of data and parity bit ≠ 1 (odd) or ≠ 0 (even).
- STOP, one sample:
  - Stop=1: push the word. Pulse parity_err if flagged. Go to IDLE.
  - Stop=0 and data all zero (parity bit also 0 if enabled): break. Pulse break_strobe. No push, no frame_err, no parity_err. Go to BREAK_WAIT.
  - Stop=0 otherwise: pulse frame_err and parity_err if flagged. Push the word anyway. Go to BREAK_WAIT.
- BREAK_WAIT: return to IDLE on the first tick with rx_s=1.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit read and write pointers.
  - Empty when the pointers are equal. Full when they differ only in the MSB.
  - Push accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the word is discarded and overrun_err pulses; FIFO contents are unchanged.
  - Pop on an empty FIFO is ignored. Pointers wrap naturally.
- Reset:
  - Any cycle, including mid-frame: FSM to IDLE, FIFO empty, synchroniser to 1.
  - All outputs 0 (rd_data 0).
  - A partial frame is lost.

## Timing
- rxd to rx_s: 2 clk latency.
- Push occurs in the clk cycle of the mid-stop-bit tick. rd_valid rises on the next clock edge; rd_data is valid the same cycle.
- Error pulses and break_strobe assert for exactly one clk, registered, in the same cycle rd_valid would first reflect the push.
- Pop: rd_data advances on the clock edge where rd_valid && rd_ready. rd_valid falls in the same edge if the FIFO becomes empty.
- Simultaneous push and pop on a full FIFO: both occur; the count is unchanged; no overrun.
- Simultaneous push and pop on an empty FIFO: the push is stored; rd_valid rises next cycle.
- Frame duration: (1 + DATA_BITS + (PARITY≠0) + 1) × OVERSAMPLE × (baud_div+1) clocks.

## Test plan
All scenarios use DATA_BITS=8, OVERSAMPLE=16, baud_div=0 (16 clk/bit) unless stated.
- PARITY=0, send 0x55, rd_ready=0 -> rd_valid=1 and rd_data=0x55 one cycle after the mid-stop tick. No error pulses. Pop with rd_ready=1 -> rd_valid=0.
- PARITY=2, send 0xA3 with parity bit 1 (wrong) -> 0xA3 pushed, parity_err pulses one cycle. Same frame with correct parity 0 -> no pulse.
- rxd low for 5 clocks then high -> no push, FSM back in IDLE. A following valid 0x3C frame -> rd_data=0x3C.
- rxd held low 200 clocks then high -> exactly one break_strobe pulse, FIFO empty, no frame_err. A subsequent 0x81 frame -> received correctly.
- FIFO_DEPTH=4, rd_ready=0, send 0x01..0x05 -> overrun_err pulses on the 5th frame. Draining returns 0x01,0x02,0x03,0x04. Repeat with rd_ready asserted in the 5th push cycle -> no overrun, and 0x05 is retained.
- Assert reset for one cycle mid-DATA of frame 0x7E -> all outputs 0, FIFO empty. The next full frame 0x12 is received correctly. With baud_div=3 the bit period measures 64 clk.
